// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader writing 32-bit words into CPU instruction memory
// Stream: header N, 4*N data bytes (MSB first), XOR checksum byte; CPU released only on a good session.
module program_loader #(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              load_mem_en,
  output logic [ADDR_W-1:0] load_mem_addr,
  output logic [31:0]       load_mem_data,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  // One extra bit so the index can reach N (== MEM_WORDS) after the final write.
  localparam int         CNT_W = ADDR_W + 1;
  localparam logic [8:0] MAX_N = 9'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    COLLECT = 3'd2,
    WRITE   = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  idx_inc;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [7:0]        xor_q, xor_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              hdr_bad;

  assign idx_inc = idx_q + CNT_W'(1);
  assign hdr_bad = (rx_byte == 8'd0) || ({1'b0, rx_byte} > MAX_N);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    xor_d       = xor_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rx_ready    = 1'b0;
    load_mem_en = 1'b0;
    cpu_rst_n   = 1'b0;
    done        = 1'b0;
    error       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = HDR;
      end

      HDR: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (hdr_bad) begin
            state_d = ERR;
          end else begin
            n_d     = rx_byte[CNT_W-1:0];
            idx_d   = '0;
            bcnt_d  = 2'd0;
            xor_d   = 8'd0;
            state_d = COLLECT;
          end
        end
      end

      COLLECT: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          asm_d  = {asm_q[23:0], rx_byte};
          xor_d  = xor_q ^ rx_byte;
          bcnt_d = bcnt_q + 2'd1;
          // Address/data are captured here so they are stable for the whole WRITE cycle and hold afterwards.
          if (bcnt_q == 2'd3) begin
            addr_d  = idx_q[ADDR_W-1:0];
            data_d  = {asm_q[23:0], rx_byte};
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        load_mem_en = 1'b1;
        idx_d       = idx_inc;
        state_d     = (idx_inc == n_q) ? CHECK : COLLECT;
      end

      CHECK: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          state_d = (rx_byte == xor_q) ? DONE : ERR;
        end
      end

      DONE: begin
        cpu_rst_n = 1'b1;
        done      = 1'b1;
        if (start) state_d = HDR;
      end

      ERR: begin
        error = 1'b1;
        if (start) state_d = HDR;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      bcnt_q  <= 2'd0;
      asm_q   <= 32'd0;
      xor_q   <= 8'd0;
      addr_q  <= '0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      xor_q   <= xor_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign load_mem_addr = addr_q;
  assign load_mem_data = data_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
// Expected writes are queued as words are driven and popped by a write monitor.
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        load_mem_en;
  logic [4:0]  load_mem_addr;
  logic [31:0] load_mem_data;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int writes_seen = 0;

  logic [4:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  exp_xor;
  logic [4:0]  next_addr;

  program_loader #(.MEM_WORDS(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_ready     (rx_ready),
    .load_mem_en  (load_mem_en),
    .load_mem_addr(load_mem_addr),
    .load_mem_data(load_mem_data),
    .cpu_rst_n    (cpu_rst_n),
    .done         (done),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_mem_en === 1'b1) begin
      logic [4:0]  ea;
      logic [31:0] ed;
      writes_seen++;
      total_cnt++;
      if (exp_addr_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", load_mem_addr, load_mem_data);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (load_mem_addr !== ea || load_mem_data !== ed)
          $display("FAIL write: got addr %0d data %h, required addr %0d data %h", load_mem_addr, load_mem_data, ea, ed);
        else
          pass_cnt++;
      end
      total_cnt++;
      if (rx_ready !== 1'b0) $display("FAIL ready_in_write: got %b required 0", rx_ready);
      else pass_cnt++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit accepted = 1'b0;
    int cyc = 0;
    if (gaps) begin
      repeat ($urandom_range(2, 0)) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1;
    rx_byte  = b;
    while (!accepted && cyc < 50) begin
      @(negedge clk);
      if (rx_ready === 1'b1) accepted = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    rx_valid = 1'b0;
    if (!accepted) begin
      total_cnt++;
      $display("FAIL byte_timeout: byte %h not accepted within 50 cycles, required acceptance", b);
    end
  endtask

  task automatic send_header(input logic [7:0] n, input bit gaps);
    exp_xor   = 8'd0;
    next_addr = 5'd0;
    send_byte(n, gaps);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    exp_addr_q.push_back(next_addr);
    exp_data_q.push_back(w);
    next_addr++;
    for (int i = 3; i >= 0; i--) begin
      exp_xor ^= w[i*8 +: 8];
      send_byte(w[i*8 +: 8], gaps);
    end
  endtask

  task automatic check_end(input string name, input logic exp_done, input logic exp_err, input int exp_writes);
    @(negedge clk);
    total_cnt++;
    if (done !== exp_done || error !== exp_err || cpu_rst_n !== exp_done)
      $display("FAIL %s_status: got done %b error %b cpu_rst_n %b, required %b %b %b",
               name, done, error, cpu_rst_n, exp_done, exp_err, exp_done);
    else pass_cnt++;
    total_cnt++;
    if (writes_seen !== exp_writes || exp_addr_q.size() != 0)
      $display("FAIL %s_writes: got %0d writes (%0d pending), required %0d", name, writes_seen, exp_addr_q.size(), exp_writes);
    else pass_cnt++;
  endtask

  task automatic check_reset_outputs(input string name);
    total_cnt++;
    if (rx_ready !== 1'b0 || load_mem_en !== 1'b0 || load_mem_addr !== 5'd0 || load_mem_data !== 32'd0 ||
        cpu_rst_n !== 1'b0 || done !== 1'b0 || error !== 1'b0)
      $display("FAIL %s: got rdy %b en %b addr %0d data %h crn %b done %b err %b, required all 0",
               name, rx_ready, load_mem_en, load_mem_addr, load_mem_data, cpu_rst_n, done, error);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_state");
  endtask

  task automatic test_single_word();
    writes_seen = 0;
    pulse_start();
    send_header(8'h01, 1'b0);
    send_word(32'h12345678, 1'b0);
    total_cnt++;
    if (exp_xor !== 8'h08) $display("FAIL model_xor: got %h required 08", exp_xor);
    else pass_cnt++;
    send_byte(8'h08, 1'b0);
    check_end("single_word", 1'b1, 1'b0, 1);
  endtask

  task automatic test_bad_header(input logic [7:0] n);
    writes_seen = 0;
    pulse_start();
    send_header(n, 1'b0);
    check_end($sformatf("bad_header_%h", n), 1'b0, 1'b1, 0);
  endtask

  task automatic test_checksum_error();
    writes_seen = 0;
    pulse_start();
    send_header(8'h02, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    send_word(32'hDEADBEEF, 1'b0);
    send_word(32'h00000001, 1'b0);
    send_byte(8'hFF, 1'b0);
    check_end("checksum_error", 1'b0, 1'b1, 2);
  endtask

  task automatic test_full_random();
    writes_seen = 0;
    pulse_start();
    send_header(8'd32, 1'b1);
    for (int i = 0; i < 32; i++) send_word($urandom, 1'b1);
    send_byte(exp_xor, 1'b1);
    check_end("full_random", 1'b1, 1'b0, 32);
  endtask

  task automatic test_restart_from_done();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (cpu_rst_n !== 1'b0 || done !== 1'b0 || error !== 1'b0 || rx_ready !== 1'b1)
      $display("FAIL restart: got crn %b done %b err %b rdy %b, required 0 0 0 1", cpu_rst_n, done, error, rx_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    writes_seen = 0;
    pulse_start();
    send_header(8'h04, 1'b0);
    send_word(32'hA1B2C3D4, 1'b0);
    send_word(32'h0F1E2D3C, 1'b0);
    w = 32'h55AA7788;
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("mid_reset_outputs");
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (writes_seen !== 2 || exp_addr_q.size() != 0)
      $display("FAIL mid_reset_writes: got %0d writes, required 2", writes_seen);
    else pass_cnt++;
    writes_seen = 0;
    pulse_start();
    send_header(8'h03, 1'b1);
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b1);
    send_byte(exp_xor, 1'b0);
    check_end("after_reset_session", 1'b1, 1'b0, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_bad_header(8'h00);
    test_bad_header(8'h21);
    test_checksum_error();
    test_full_random();
    test_restart_from_done();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEM_WORDS, default 32, number of instruction-memory words that can be loaded.
REQ-002 Parameter ADDR_W, default 5, width of the word address (log2 MEM_WORDS).
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, reset, synchronous and active-high.
REQ-005 Port start, input, 1, single-cycle request to begin a load session.
REQ-006 Port rx_valid, input, 1, a byte is offered on rx_byte.
REQ-007 Port rx_byte, input, 8, the offered stream byte.
REQ-008 Port rx_ready, output, 1, the loader accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both 1.
REQ-009 Port load_mem_en, output, 1, instruction-memory write strobe, driving the CPU load_mem_en input.
REQ-010 Port load_mem_addr, output, ADDR_W, word address of the write.
REQ-011 Port load_mem_data, output, 32, instruction word of the write.
REQ-012 Port cpu_rst_n, output, 1, active-low hold for the CPU core; 0 keeps the CPU in reset.
REQ-013 Port done, output, 1, the session completed with a good checksum.
REQ-014 Port error, output, 1, the session aborted because of a bad header or checksum.

Function
REQ-015 The FSM SHALL have the states IDLE, HDR, COLLECT, WRITE, CHECK, DONE and ERR.
REQ-016 The stream format SHALL be: 1 header byte N (word count), then 4*N data bytes (each word MSB first), then 1 checksum byte equal to the XOR of all 4*N data bytes.
REQ-017 rx_ready SHALL be 1 only in HDR, COLLECT and CHECK; it SHALL be 0 in IDLE, WRITE, DONE and ERR.
REQ-018 IDLE: when start=1, the FSM SHALL go to HDR on the next cycle; otherwise it SHALL stay in IDLE.
REQ-019 HDR, on an accepted byte:
- if N=0 or N>MEM_WORDS, the FSM SHALL go to ERR;
- otherwise it SHALL latch N, clear the word index, clear the byte count and clear the running XOR, then go to COLLECT.
REQ-020 COLLECT, on each accepted byte: shift assembly = {assembly[23:0], rx_byte}, XOR rx_byte into the checksum, and increment the 2-bit byte count.
REQ-021 COLLECT SHALL go to WRITE on the cycle after the 4th byte of a word is accepted.
REQ-022 WRITE SHALL last exactly one cycle with load_mem_en=1, load_mem_addr=word index and load_mem_data=assembled word.
REQ-023 Leaving WRITE, the word index SHALL increment; the next state SHALL be CHECK if the new index equals N, otherwise COLLECT.
REQ-024 CHECK, on an accepted byte: if it equals the running XOR, go to DONE, otherwise go to ERR.
REQ-025 Latency from the accepted checksum byte to done=1 (or error=1) SHALL be 1 cycle.
REQ-026 load_mem_en SHALL be 0 in every state other than WRITE; load_mem_addr and load_mem_data SHALL hold their last values outside WRITE.
REQ-027 cpu_rst_n SHALL be 1 only in DONE.
REQ-028 done SHALL be 1 only in DONE, and error SHALL be 1 only in ERR.
REQ-029 start SHALL be ignored in HDR, COLLECT, WRITE and CHECK.
REQ-030 start in DONE or ERR SHALL begin a new session: next state HDR, cpu_rst_n=0 on that same next cycle, and done and error both cleared.
REQ-031 The word index SHALL never exceed N-1 at a write, so no address wrap-around occurs.
REQ-032 For N=MEM_WORDS, the last write SHALL use address MEM_WORDS-1.
REQ-033 rx_valid while rx_ready=0 SHALL NOT consume the byte; the upstream holds it until rx_ready=1.

Reset
REQ-034 While rst=1 at a clock edge, the loader SHALL enter IDLE with rx_ready=0, load_mem_en=0, load_mem_addr=0, load_mem_data=0, cpu_rst_n=0, done=0 and error=0.
REQ-035 The word index, byte count, N, assembly register and running XOR SHALL all be cleared by reset.
REQ-036 Reset asserted mid-session SHALL abort the session the next cycle with no further load_mem_en pulse; words already written SHALL remain in memory.

Verification
REQ-037 start, then stream 0x01,0x12,0x34,0x56,0x78,0x08 -> one load_mem_en pulse with addr 0 and data 0x12345678; done=1 and cpu_rst_n=1 one cycle after 0x08 is accepted.
REQ-038 Header byte 0x00, and separately 0x21 -> error=1, no load_mem_en, cpu_rst_n stays 0.
REQ-039 N=2, words 0xDEADBEEF then 0x00000001, checksum byte 0xFF -> writes at addresses 0 and 1, then error=1 (the correct checksum is 0x23), cpu_rst_n=0.
REQ-040 N=32 with rx_valid toggled pseudo-randomly -> 32 writes at addresses 0..31 in order, rx_ready=0 during each WRITE cycle, then done=1.
REQ-041 rst asserted after the 3rd word's 2nd byte of an N=4 session -> exactly 2 writes observed, all outputs at reset values next cycle; a following start plus a good stream completes normally.
REQ-042 In DONE, pulse start -> cpu_rst_n drops to 0 and done drops to 0 the next cycle, with the FSM in HDR.
